// File: rtl/booth_pkg.sv
//============================================================================
// Module   : booth_pkg
// Brief    : Shared widths and queue entry type for the Booth operand stager.
//            Tag field present only when BOOTH_STAGER_TAG_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package booth_pkg;

    localparam int WIDTH  = 521;
    localparam int CNT_W  = 10;
    localparam int TAG_W  = 4;
    localparam int PERIOD = WIDTH + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
`ifdef BOOTH_STAGER_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
    } op_entry_t;

endpackage

`default_nettype wire

// File: rtl/booth_stager_fifo.sv
//============================================================================
// Module   : booth_stager_fifo
// Brief    : DEPTH-entry synchronous first-word-fall-through FIFO of operand
//            entries. DEPTH must be a power of two.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module booth_stager_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  op_entry_t push_data,
    input  logic      pop,
    output op_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign head   = r_mem[r_rd_ptr];

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/booth_operand_stager.sv
//============================================================================
// Module   : booth_operand_stager
// Brief    : Queues operand pairs and presents them to the iterative Booth
//            multiplier, frozen for a full period; flags real products.
//            Optional tag tracking via BOOTH_STAGER_TAG_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module booth_operand_stager
    import booth_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [CNT_W-1:0] phase,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag
);

    logic [CNT_W-1:0] r_phase;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic             r_slot_valid;
    logic             r_res_valid;
    logic             w_load;
    logic             w_full;
    logic             w_empty;
    op_entry_t        w_in_entry;
    op_entry_t        w_head;

    assign w_load    = (r_phase == CNT_W'(1));
    assign in_ready  = !w_full;
    assign phase     = r_phase;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign res_valid = r_res_valid;

    always_comb begin
        w_in_entry   = '0;
        w_in_entry.a = in_a;
        w_in_entry.b = in_b;
`ifdef BOOTH_STAGER_TAG_EN
        w_in_entry.tag = in_tag;
`endif
    end

    booth_stager_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (w_in_entry),
        .pop       (w_load),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Mirror of the multiplier's iteration counter: 0, WIDTH, WIDTH-1 .. 1, 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (r_phase != '0) begin
            r_phase <= r_phase - CNT_W'(1);
        end else begin
            r_phase <= CNT_W'(PERIOD - 1);
        end
    end

    // Load edge: the multiplier captures c from the outgoing slot while the
    // next pair (or zeros when idle) is latched for the coming period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_slot_valid <= 1'b0;
            r_res_valid  <= 1'b0;
        end else begin
            r_res_valid <= w_load && r_slot_valid;
            if (w_load) begin
                if (!w_empty) begin
                    r_mul_a      <= w_head.a;
                    r_mul_b      <= w_head.b;
                    r_slot_valid <= 1'b1;
                end else begin
                    r_mul_a      <= '0;
                    r_mul_b      <= '0;
                    r_slot_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BOOTH_STAGER_TAG_EN
    logic [TAG_W-1:0] r_slot_tag;
    logic [TAG_W-1:0] r_res_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_tag <= '0;
            r_res_tag  <= '0;
        end else if (w_load) begin
            r_res_tag  <= r_slot_tag;
            r_slot_tag <= w_empty ? '0 : w_head.tag;
        end
    end

    assign res_tag = r_res_tag;
`else
    logic w_unused_tag;

    assign w_unused_tag = ^in_tag;
    assign res_tag      = '0;
`endif

endmodule

`default_nettype wire
